clause_scan_engine: RTL and testbench

CLAUSE_SCAN_ENGINE -- requirements
Module: clause_scan_engine

---
 rtl/sat_pkg.sv | 31 +++
 rtl/clause_lane_eval.sv | 35 +++
 rtl/clause_scan_engine.sv | 154 +++++++++++++++
 tb/tb_clause_scan_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Literal encoding, literal enum and scan FSM state type shared by the clause scan engine.
package sat_pkg;

    localparam int          LIT_W          = 2;
    localparam logic [1:0]  ENC_UNASSIGNED = 2'b00;
    localparam logic [1:0]  ENC_TRUE       = 2'b01;
    localparam logic [1:0]  ENC_FALSE      = 2'b10;

    typedef enum logic [1:0] {
        UNASSIGNED = ENC_UNASSIGNED,
        TRUE       = ENC_TRUE,
        FALSE      = ENC_FALSE
    } lit_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

    // 2'b11 is not a legal code and is read as UNASSIGNED.
    function automatic lit_t decode_lit(input logic [LIT_W-1:0] raw);
        case (raw)
            ENC_TRUE:  return TRUE;
            ENC_FALSE: return FALSE;
            default:   return UNASSIGNED;
        endcase
    endfunction

endpackage

// File: rtl/clause_lane_eval.sv
// Combinational classifier for one clause: satisfied, conflicting (all FALSE) or unit
// (exactly one UNASSIGNED literal, all others FALSE).
module clause_lane_eval
    import sat_pkg::*;
#(
    parameter int NUM_VARS = 3
) (
    input  logic [NUM_VARS*LIT_W-1:0] clause_i,
    output logic                      sat_o,
    output logic                      conflict_o,
    output logic                      unit_o
);

    localparam int CNT_W = $clog2(NUM_VARS + 1);

    logic [CNT_W-1:0] n_true;
    logic [CNT_W-1:0] n_false;

    always_comb begin
        n_true  = '0;
        n_false = '0;
        for (int v = 0; v < NUM_VARS; v++) begin
            case (decode_lit(clause_i[v*LIT_W +: LIT_W]))
                TRUE:    n_true  = n_true + CNT_W'(1);
                FALSE:   n_false = n_false + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign sat_o      = (n_true != '0);
    assign conflict_o = (n_false == CNT_W'(NUM_VARS));
    assign unit_o     = (n_true == '0) && (n_false == CNT_W'(NUM_VARS - 1));

endmodule

// File: rtl/clause_scan_engine.sv
// Streams clause chunks from memory, LANES clauses per cycle, and reports conflict/unit/all-sat.
// Optional build macro CLAUSE_SCAN_EARLY_EXIT_EN ends the pass on the first conflicting chunk.
module clause_scan_engine
    import sat_pkg::*;
#(
    parameter  int NUM_CLAUSES         = 64,
    parameter  int NUM_VARS_PER_CLAUSE = 3,
    parameter  int LANES               = 4,
    localparam int C                   = NUM_CLAUSES / LANES,
    localparam int IDX_W               = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
    localparam int CHUNK_W             = (C > 1) ? $clog2(C) : 1,
    localparam int CLAUSE_W            = NUM_VARS_PER_CLAUSE * LIT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        rd_en,
    output logic [CHUNK_W-1:0]          rd_addr,
    input  logic [LANES*CLAUSE_W-1:0]   rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        unsatisfied,
    output logic [IDX_W-1:0]            conflict_idx,
    output logic                        unit_found,
    output logic [IDX_W-1:0]            unit_idx,
    output logic                        all_sat
);

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(C - 1);

    scan_state_t          state_q, state_d;
    logic [CHUNK_W-1:0]   rd_addr_q;
    logic                 vld_p1_q;
    logic [CHUNK_W-1:0]   chunk_p1_q;
    logic                 unsat_q, unit_q, all_sat_q;
    logic [IDX_W-1:0]     conflict_idx_q, unit_idx_q;

    logic [LANES-1:0]     lane_sat, lane_conf, lane_unit;
    logic                 any_conf, any_unit;
    logic [IDX_W-1:0]     conf_idx_c, unit_idx_c;
    logic                 accept, early_stop;

    function automatic logic [IDX_W-1:0] clause_index(input logic [CHUNK_W-1:0] chunk,
                                                      input int lane);
        return IDX_W'(chunk) * IDX_W'(LANES) + IDX_W'(lane);
    endfunction

    assign accept = (state_q == IDLE) && start;

    // ---- stage p1: chunk data returned by memory, evaluated lane by lane ----
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        clause_lane_eval #(
            .NUM_VARS (NUM_VARS_PER_CLAUSE)
        ) u_lane (
            .clause_i   (rd_data[l*CLAUSE_W +: CLAUSE_W]),
            .sat_o      (lane_sat[l]),
            .conflict_o (lane_conf[l]),
            .unit_o     (lane_unit[l])
        );
    end

    // Descending loop so the lowest lane is the last writer and wins.
    always_comb begin
        any_conf   = 1'b0;
        any_unit   = 1'b0;
        conf_idx_c = '0;
        unit_idx_c = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_conf[l]) begin
                any_conf   = 1'b1;
                conf_idx_c = clause_index(chunk_p1_q, l);
            end
            if (lane_unit[l]) begin
                any_unit   = 1'b1;
                unit_idx_c = clause_index(chunk_p1_q, l);
            end
        end
    end

`ifdef CLAUSE_SCAN_EARLY_EXIT_EN
    assign early_stop = vld_p1_q && any_conf;
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (early_stop) state_d = DONE;
                     else if (rd_addr_q == LAST_CHUNK) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p0: issue chunk reads ----
    assign rd_en   = (state_q == SCAN) && !early_stop;
    assign rd_addr = rd_addr_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_p1_q <= rd_en;
            if (accept) rd_addr_q <= '0;
            else if (rd_en) rd_addr_q <= rd_addr_q + CHUNK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        chunk_p1_q <= rd_addr_q;
    end

    // ---- stage p2: sticky result registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unsat_q        <= 1'b0;
            unit_q         <= 1'b0;
            all_sat_q      <= 1'b0;
            conflict_idx_q <= '0;
            unit_idx_q     <= '0;
        end else if (accept) begin
            unsat_q        <= 1'b0;
            unit_q         <= 1'b0;
            all_sat_q      <= 1'b1;
            conflict_idx_q <= '0;
            unit_idx_q     <= '0;
        end else if (vld_p1_q) begin
            if (any_conf && !unsat_q) begin
                unsat_q        <= 1'b1;
                conflict_idx_q <= conf_idx_c;
            end
            if (any_unit && !unit_q) begin
                unit_q     <= 1'b1;
                unit_idx_q <= unit_idx_c;
            end
            if (!(&lane_sat)) all_sat_q <= 1'b0;
        end
    end

    assign unsatisfied  = unsat_q;
    assign conflict_idx = conflict_idx_q;
    assign unit_found   = unit_q;
    assign unit_idx     = unit_idx_q;
    assign all_sat      = all_sat_q;

endmodule

// File: tb/tb_clause_scan_engine.sv
// Randomised bench for clause_scan_engine (8 clauses, 3 literals, 2 lanes) against a clause-level model.
module tb_clause_scan_engine;

    localparam int NC      = 8;
    localparam int NV      = 3;
    localparam int L       = 2;
    localparam int C       = NC / L;
    localparam int IDX_W   = 3;
    localparam int CHUNK_W = 2;
    localparam int CW      = 2 * NV;
    localparam int DW      = L * CW;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               rd_en;
    logic [CHUNK_W-1:0] rd_addr;
    logic [DW-1:0]      rd_data = '0;
    logic               busy, done, unsatisfied, unit_found, all_sat;
    logic [IDX_W-1:0]   conflict_idx, unit_idx;

    int checks = 0;
    int errors = 0;

    logic [1:0] lits [NC][NV];

    always #5 clk = ~clk;

    clause_scan_engine #(
        .NUM_CLAUSES         (NC),
        .NUM_VARS_PER_CLAUSE (NV),
        .LANES               (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .unsatisfied  (unsatisfied),
        .conflict_idx (conflict_idx),
        .unit_found   (unit_found),
        .unit_idx     (unit_idx),
        .all_sat      (all_sat)
    );

    function automatic logic [DW-1:0] pack_chunk(input logic [CHUNK_W-1:0] k);
        logic [DW-1:0] r;
        r = '0;
        for (int ln = 0; ln < L; ln++)
            for (int v = 0; v < NV; v++)
                r[ln*CW + 2*v +: 2] = lits[int'(k)*L + ln][v];
        return r;
    endfunction

    // Clause memory: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        if (rd_en) rd_data <= pack_chunk(rd_addr);
        else       rd_data <= DW'($urandom);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] rand_lit(input int pct_true);
        int r;
        r = $urandom_range(0, 99);
        if (r < pct_true) return 2'b01;
        if (r < pct_true + ((100 - pct_true) * 7) / 10) return 2'b10;
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic fill_random(input int pct_true);
        for (int i = 0; i < NC; i++)
            for (int v = 0; v < NV; v++)
                lits[i][v] = rand_lit(pct_true);
    endtask

    // Clause-level reference: classify each clause by counting literal values.
    task automatic model(output int lat, output int reads, output bit e_uns, output int e_cidx,
                         output bit e_unit, output int e_uidx, output bit e_all);
        int nt, nf, limit;
        e_uns = 0; e_cidx = 0; e_unit = 0; e_uidx = 0; e_all = 1;
        for (int i = 0; i < NC; i++) begin
            nt = 0; nf = 0;
            for (int v = 0; v < NV; v++) begin
                if (lits[i][v] == 2'b01) nt++;
                if (lits[i][v] == 2'b10) nf++;
            end
            if (nt == 0) e_all = 0;
            if (nf == NV && !e_uns) begin e_uns = 1; e_cidx = i; end
        end
        limit = NC; reads = C; lat = C + 2;
`ifdef CLAUSE_SCAN_EARLY_EXIT_EN
        if (e_uns) begin
            limit = (e_cidx / L + 1) * L;
            reads = e_cidx / L + 1;
            lat   = e_cidx / L + 3;
        end
`endif
        for (int i = 0; i < limit; i++) begin
            nt = 0; nf = 0;
            for (int v = 0; v < NV; v++) begin
                if (lits[i][v] == 2'b01) nt++;
                if (lits[i][v] == 2'b10) nf++;
            end
            if (nt == 0 && nf == NV - 1 && !e_unit) begin e_unit = 1; e_uidx = i; end
        end
    endtask

    task automatic check_results(input string nm, input bit e_uns, input int e_cidx,
                                 input bit e_unit, input int e_uidx, input bit e_all);
        check_val({nm, ".unsatisfied"},  32'(unsatisfied),  32'(e_uns));
        check_val({nm, ".conflict_idx"}, 32'(conflict_idx), e_cidx);
        check_val({nm, ".unit_found"},   32'(unit_found),   32'(e_unit));
        check_val({nm, ".unit_idx"},     32'(unit_idx),     e_uidx);
        check_val({nm, ".all_sat"},      32'(all_sat),      32'(e_all));
    endtask

    // One pass: start at cycle T, then observe cycles T+1.. at the falling edge.
    task automatic run_pass(input string nm, input int ign_at, input bit ign_done);
        int lat, reads, e_cidx, e_uidx, dcnt, dcyc;
        bit e_uns, e_unit, e_all;
        model(lat, reads, e_uns, e_cidx, e_unit, e_uidx, e_all);
        @(negedge clk);
        start = 1'b1;
        dcnt = 0; dcyc = -1;
        for (int n = 1; n <= C + 8; n++) begin
            @(negedge clk);
            start = 1'b0;
            check_val($sformatf("%s.rd_en@%0d", nm, n), 32'(rd_en), 32'(n <= reads));
            if (n <= reads)
                check_val($sformatf("%s.rd_addr@%0d", nm, n), 32'(rd_addr), n - 1);
            check_val($sformatf("%s.busy@%0d", nm, n), 32'(busy), 32'(n <= lat));
            if (done) begin
                dcnt++;
                if (dcyc < 0) dcyc = n;
            end
            if (n == ign_at) start = 1'b1;
            if (ign_done && done) start = 1'b1;
        end
        start = 1'b0;
        check_val({nm, ".done_cycle"}, dcyc, lat);
        check_val({nm, ".done_count"}, dcnt, 1);
        check_results(nm, e_uns, e_cidx, e_unit, e_uidx, e_all);
    endtask

    task automatic check_all_zero(input string nm);
        check_val({nm, ".rd_en"},   32'(rd_en),   0);
        check_val({nm, ".rd_addr"}, 32'(rd_addr), 0);
        check_val({nm, ".busy"},    32'(busy),    0);
        check_val({nm, ".done"},    32'(done),    0);
        check_results(nm, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++)
            for (int v = 0; v < NV; v++)
                lits[i][v] = 2'b01;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Every clause has exactly one TRUE literal.
        for (int i = 0; i < NC; i++) begin
            int p;
            p = $urandom_range(0, NV - 1);
            for (int v = 0; v < NV; v++)
                lits[i][v] = (v == p) ? 2'b01 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b00);
        end
        run_pass("allsat", 0, 0);

        // Clauses 5 and 6 all FALSE.
        for (int i = 0; i < NC; i++)
            for (int v = 0; v < NV; v++)
                lits[i][v] = (i == 5 || i == 6) ? 2'b10 : 2'b01;
        run_pass("conflict", 0, 0);

        // Units at clause 3 and clause 7 (2'b11 counts as UNASSIGNED).
        for (int i = 0; i < NC; i++)
            for (int v = 0; v < NV; v++)
                lits[i][v] = 2'b01;
        lits[3][0] = 2'b10; lits[3][1] = 2'b00; lits[3][2] = 2'b10;
        lits[7][0] = 2'b11; lits[7][1] = 2'b10; lits[7][2] = 2'b10;
        run_pass("unit", 0, 0);

        // Starts during SCAN and on the DONE cycle are ignored.
        fill_random(40);
        run_pass("ignore", 2, 1);
        check_val("ignore.idle_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a pass, clause 0 conflicting.
        fill_random(60);
        for (int v = 0; v < NV; v++) lits[0][v] = 2'b10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midreset.pre_unsat", 32'(unsatisfied), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        check_val("midreset.held_busy", 32'(busy), 0);
        rst_n = 1'b1;
        fill_random(50);
        run_pass("after_reset", 0, 0);

        for (int k = 0; k < 20; k++) begin
            fill_random($urandom_range(15, 90));
            run_pass($sformatf("rand%0d", k), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
